// File: rtl/segment_scroll_txt_if.sv
// rtl/segment_scroll_txt_if.sv - character write port bundle for segment_scroll_txt
interface segment_scroll_txt_if;
    logic       wr_valid;
    logic [5:0] wr_data;
    logic       wr_ready;

    modport master (output wr_valid, output wr_data, input wr_ready);
    modport slave  (input wr_valid, input wr_data, output wr_ready);
endinterface

// File: rtl/segment_scroll_txt.sv
// rtl/segment_scroll_txt.sv - buffered 7-segment text display with digit multiplexing and marquee scroll
// Glyph table: active-low, bit 0 = segment a ... bit 6 = segment g.
module segment_ram_txt (
    input  logic [5:0] i_code,
    output logic [6:0] o_seg
);
    always_comb begin
        o_seg = 7'h7F;
        case (i_code)
            6'h00: o_seg = 7'h40;
            6'h01: o_seg = 7'h79;
            6'h02: o_seg = 7'h24;
            6'h03: o_seg = 7'h30;
            6'h04: o_seg = 7'h19;
            6'h05: o_seg = 7'h12;
            6'h06: o_seg = 7'h02;
            6'h07: o_seg = 7'h78;
            6'h08: o_seg = 7'h00;
            6'h09: o_seg = 7'h10;
            6'h0A: o_seg = 7'h08;
            6'h0B: o_seg = 7'h03;
            6'h0C: o_seg = 7'h46;
            6'h0D: o_seg = 7'h21;
            6'h0E: o_seg = 7'h06;
            6'h0F: o_seg = 7'h0E;
            6'h10: o_seg = 7'h42;
            6'h11: o_seg = 7'h0B;
            6'h12: o_seg = 7'h4F;
            6'h13: o_seg = 7'h61;
            6'h14: o_seg = 7'h0A;
            6'h15: o_seg = 7'h47;
            6'h16: o_seg = 7'h48;
            6'h17: o_seg = 7'h2B;
            6'h18: o_seg = 7'h23;
            6'h19: o_seg = 7'h0C;
            6'h1A: o_seg = 7'h18;
            6'h1B: o_seg = 7'h2F;
            6'h1C: o_seg = 7'h12;
            6'h1D: o_seg = 7'h07;
            6'h1E: o_seg = 7'h41;
            6'h1F: o_seg = 7'h63;
            6'h20: o_seg = 7'h15;
            6'h21: o_seg = 7'h09;
            6'h22: o_seg = 7'h11;
            6'h23: o_seg = 7'h24;
            6'h24: o_seg = 7'h3F;
            default: o_seg = 7'h7F;
        endcase
    end
endmodule

module segment_scroll_txt #(
    parameter int DIGITS     = 8,
    parameter int DEPTH      = 32,
    parameter int MUX_DIV    = 50000,
    parameter int SCROLL_DIV = 25000000
) (
    input  logic                       i_clk,
    input  logic                       i_rst_n,
    input  logic                       i_clr,
    input  logic                       i_mode,
    segment_scroll_txt_if.slave        wr,
    output logic [$clog2(DEPTH+1)-1:0] o_len,
    output logic                       o_wrap,
    output logic [6:0]                 o_seg,
    output logic [DIGITS-1:0]          o_an
);
    localparam int LW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH + DIGITS);
    localparam int IW = PW + 2;
    localparam int BW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int DW = $clog2(DIGITS);
    localparam int MW = $clog2(MUX_DIV);
    localparam int SW = $clog2(SCROLL_DIV);

    logic [5:0]    r_buf [DEPTH];
    logic [LW-1:0] r_len;
    logic [PW-1:0] r_p;
    logic [SW-1:0] r_scr_cnt;
    logic [MW-1:0] r_mux_cnt;
    logic [DW-1:0] r_d;
    logic          r_wrap;
    logic [6:0]    r_seg;
    logic [DIGITS-1:0] r_an;

    logic          w_accept;
    logic          w_mux_tick;
    logic [DW-1:0] w_d_next;
    logic [IW-1:0] w_virt_len;
    logic [IW-1:0] w_sum;
    logic [IW-1:0] w_idx;
    logic          w_in_msg;
    logic [5:0]    w_code;
    logic [6:0]    w_glyph;
    logic          w_p_last;

    assign wr.wr_ready = (r_len < LW'(DEPTH));
    assign w_accept    = wr.wr_valid && wr.wr_ready && !i_clr;

    // Message is followed by DIGITS blanks; p < L and k < DIGITS <= L, so one subtraction wraps the sum.
    assign w_virt_len = IW'(r_len) + IW'(DIGITS);
    assign w_d_next   = (r_d == DW'(DIGITS - 1)) ? '0 : r_d + 1'b1;
    assign w_sum      = IW'(r_p) + IW'(w_d_next);
    assign w_idx      = (w_sum >= w_virt_len) ? (w_sum - w_virt_len) : w_sum;
    assign w_in_msg   = (w_idx < IW'(r_len));
    assign w_code     = w_in_msg ? r_buf[w_idx[BW-1:0]] : 6'h3F;
    assign w_p_last   = (IW'(r_p) == (w_virt_len - 1'b1));
    assign w_mux_tick = (r_mux_cnt == MW'(MUX_DIV - 1));

    segment_ram_txt u_glyph (
        .i_code (w_code),
        .o_seg  (w_glyph)
    );

    always_ff @(posedge i_clk) begin
        if (w_accept) begin
            r_buf[r_len[BW-1:0]] <= wr.wr_data;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_len <= '0;
        end else if (i_clr) begin
            r_len <= '0;
        end else if (w_accept) begin
            r_len <= r_len + 1'b1;
        end
    end

    // Scroll position only advances while scrolling a non-empty message.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_p       <= '0;
            r_scr_cnt <= '0;
            r_wrap    <= 1'b0;
        end else begin
            r_wrap <= 1'b0;
            if (i_clr || !i_mode || (r_len == '0)) begin
                r_p       <= '0;
                r_scr_cnt <= '0;
            end else if (r_scr_cnt == SW'(SCROLL_DIV - 1)) begin
                r_scr_cnt <= '0;
                if (w_p_last) begin
                    r_p    <= '0;
                    r_wrap <= 1'b1;
                end else begin
                    r_p <= r_p + 1'b1;
                end
            end else begin
                r_scr_cnt <= r_scr_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_mux_cnt <= '0;
            r_d       <= DW'(DIGITS - 1);
            r_seg     <= 7'h7F;
            r_an      <= '1;
        end else if (w_mux_tick) begin
            r_mux_cnt <= '0;
            r_d       <= w_d_next;
            r_seg     <= w_glyph;
            r_an      <= ~(DIGITS'(1) << w_d_next);
        end else begin
            r_mux_cnt <= r_mux_cnt + 1'b1;
        end
    end

    assign o_len  = r_len;
    assign o_wrap = r_wrap;
    assign o_seg  = r_seg;
    assign o_an   = r_an;
endmodule

// File: tb/tb_segment_scroll_txt.sv
// tb/tb_segment_scroll_txt.sv - self-checking bench for segment_scroll_txt
module tb_segment_scroll_txt;
    localparam int DIGITS = 4, DEPTH = 8, MUX_DIV = 4, SCROLL_DIV = 64;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       clr = 1'b0;
    logic       mode = 1'b0;
    logic [3:0] len;
    logic       wrap;
    logic [6:0] seg;
    logic [3:0] an;

    segment_scroll_txt_if wr_if ();

    segment_scroll_txt #(
        .DIGITS(DIGITS), .DEPTH(DEPTH), .MUX_DIV(MUX_DIV), .SCROLL_DIV(SCROLL_DIV)
    ) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_clr(clr), .i_mode(mode), .wr(wr_if),
        .o_len(len), .o_wrap(wrap), .o_seg(seg), .o_an(an)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail = 0;
    int m_buf [DEPTH];
    int m_len, m_p, m_sc, m_n;
    logic [6:0] m_seg;
    logic [3:0] m_an;
    logic       m_wrap;
    logic       cmp_en = 1'b0;
    int wrap_seen = 0;
    int wrap_n = 0;

    function automatic logic [6:0] glyph(input int c);
        case (c)
            0: return 7'h40;  1: return 7'h79;  2: return 7'h24;  3: return 7'h30;
            4: return 7'h19;  5: return 7'h12;  6: return 7'h02;  7: return 7'h78;
            8: return 7'h00;  10: return 7'h08; 14: return 7'h06; 17: return 7'h0B;
            21: return 7'h47; 36: return 7'h3F;
            default: return (c >= 37) ? 7'h7F : 7'hxx;
        endcase
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_len = 0; m_p = 0; m_sc = 0; m_n = 0;
        m_seg = 7'h7F; m_an = 4'hF; m_wrap = 1'b0;
    endtask

    // Edge-level model: what each pin must hold after this clock edge.
    task automatic model_edge();
        int pre_len, pre_p, k, idx;
        if (!rst_n) return;
        m_n++;
        pre_len = m_len;
        pre_p = m_p;
        if (m_n % MUX_DIV == 0) begin
            k = (m_n / MUX_DIV - 1) % DIGITS;
            idx = (pre_p + k) % (pre_len + DIGITS);
            m_seg = (idx < pre_len) ? glyph(m_buf[idx]) : 7'h7F;
            m_an = ~(4'b0001 << k);
        end
        m_wrap = 1'b0;
        if (clr || !mode || pre_len == 0) begin
            m_p = 0; m_sc = 0;
        end else begin
            m_sc++;
            if (m_sc == SCROLL_DIV) begin
                m_sc = 0;
                if (m_p == pre_len + DIGITS - 1) begin m_p = 0; m_wrap = 1'b1; end
                else m_p++;
            end
        end
        if (clr) m_len = 0;
        else if (wr_if.wr_valid && m_len < DEPTH) begin
            m_buf[m_len] = int'(wr_if.wr_data);
            m_len++;
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && cmp_en) begin
            chk("seg", seg, m_seg);
            chk("an", an, m_an);
            chk("len", len, m_len);
            chk("wrap", wrap, m_wrap);
            chk("ready", wr_if.wr_ready, (m_len < DEPTH));
            if (wrap) begin wrap_seen++; wrap_n = m_n; end
        end
    end

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic write_code(input int c);
        wr_if.wr_valid = 1'b1;
        wr_if.wr_data = 6'(c);
        tick();
        wr_if.wr_valid = 1'b0;
    endtask

    task automatic wait_digit(input int k);
        int b = 0;
        do begin tick(); b++; end
        while (!((m_n % MUX_DIV) == 0 && ((m_n / MUX_DIV - 1) % DIGITS) == k) && b < 64);
        if (b >= 64) begin
            n_checks++; n_fail++;
            $display("FAIL digit_timeout: digit %0d not refreshed within 64 cycles", k);
        end
    endtask

    task automatic wait_p(input int v);
        int b = 0;
        do begin tick(); b++; end while (m_p != v && b < 200);
        if (b >= 200) begin
            n_checks++; n_fail++;
            $display("FAIL p_timeout: position %0d not reached", v);
        end
    endtask

    task automatic pulse_clr();
        clr = 1'b1; tick(); clr = 1'b0;
    endtask

    initial begin
        int s, b;
        wr_if.wr_valid = 1'b0;
        wr_if.wr_data = '0;
        model_reset();
        repeat (3) tick();
        chk("rst_seg", seg, 7'h7F);
        chk("rst_an", an, 4'b1111);
        chk("rst_len", len, 0);
        chk("rst_ready", wr_if.wr_ready, 1);
        chk("rst_wrap", wrap, 0);
        rst_n = 1'b1;
        cmp_en = 1'b1;
        repeat (4) tick();
        chk("cyc4_an", an, 4'b1110);
        chk("cyc4_seg", seg, 7'h7F);

        // Static "HELL"
        mode = 1'b0;
        write_code(8'h11); write_code(8'h0E); write_code(8'h15); write_code(8'h15);
        wait_digit(0); chk("st_seg0", seg, 7'h0B); chk("st_an0", an, 4'b1110);
        wait_digit(1); chk("st_seg1", seg, 7'h06); chk("st_an1", an, 4'b1101);
        wait_digit(2); chk("st_seg2", seg, 7'h47); chk("st_an2", an, 4'b1011);
        wait_digit(3); chk("st_seg3", seg, 7'h47); chk("st_an3", an, 4'b0111);
        wait_digit(0); chk("st_seg0_again", seg, 7'h0B);

        // Full buffer: nine back-to-back codes, only eight fit
        pulse_clr();
        wr_if.wr_valid = 1'b1;
        for (int i = 0; i < 9; i++) begin wr_if.wr_data = 6'(i); tick(); end
        wr_if.wr_valid = 1'b0;
        chk("full_len", len, 8);
        chk("full_ready", wr_if.wr_ready, 0);
        wait_digit(0); chk("full_seg0", seg, 7'h40);
        wait_digit(3); chk("full_seg3", seg, 7'h30);

        // Scroll "A-" with L = 6
        pulse_clr();
        write_code(8'h0A); write_code(8'h24);
        wrap_seen = 0;
        mode = 1'b1;
        s = m_n + 1;
        wait_digit(0); chk("sc0_d0", seg, 7'h08);
        wait_digit(1); chk("sc0_d1", seg, 7'h3F);
        wait_digit(2); chk("sc0_d2", seg, 7'h7F);
        wait_digit(3); chk("sc0_d3", seg, 7'h7F);
        wait_p(1);
        wait_digit(0); chk("sc1_d0", seg, 7'h3F);
        wait_digit(1); chk("sc1_d1", seg, 7'h7F);
        b = 0;
        while (wrap_seen == 0 && b < 500) begin tick(); b++; end
        chk("wrap_seen", wrap_seen, 1);
        chk("wrap_time", wrap_n - s + 1, 6 * SCROLL_DIV);
        wait_digit(0); chk("sc_ret_d0", seg, 7'h08);
        wait_digit(1); chk("sc_ret_d1", seg, 7'h3F);

        // Clear with a simultaneous write while scrolling
        wrap_seen = 0;
        clr = 1'b1; wr_if.wr_valid = 1'b1; wr_if.wr_data = 6'h05;
        tick();
        clr = 1'b0; wr_if.wr_valid = 1'b0;
        chk("clr_len", len, 0);
        chk("clr_ready", wr_if.wr_ready, 1);
        for (int k = 0; k < DIGITS; k++) begin
            wait_digit(k);
            chk("clr_blank", seg, 7'h7F);
        end
        repeat (400) tick();
        chk("clr_no_wrap", wrap_seen, 0);

        // Asynchronous reset between clock edges mid-scroll
        write_code(8'h01); write_code(8'h02); write_code(8'h03);
        repeat (100) tick();
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("arst_seg", seg, 7'h7F);
        chk("arst_an", an, 4'b1111);
        chk("arst_len", len, 0);
        repeat (2) tick();
        mode = 1'b0;
        rst_n = 1'b1;
        write_code(8'h0A);
        wait_digit(0); chk("restart_d0", seg, 7'h08);
        wait_digit(1); chk("restart_d1", seg, 7'h7F);

        cmp_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
